// File: rtl/box_sprite_renderer.sv
// Per-frame snapshot of N boxes, per-line coverage mask built in horizontal blank,
// and a 2-stage pixel pipeline resolving each pixel to a 6-bit {R,G,B} colour.
module box_sprite_renderer #(
   parameter int          SCREEN_W = 640,
   parameter int          SCREEN_H = 480,
   parameter int          H_TOTAL  = 800,
   parameter int          V_TOTAL  = 525,
   parameter int          BOX_W    = 48,
   parameter int          BOX_H    = 32,
   parameter int          N        = 8,
   parameter logic [5:0]  BG_RGB   = 6'b000001
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              frame_tick,
   input  logic [9:0]        hpos,
   input  logic [9:0]        vpos,
   input  logic              video_active,
   input  logic [10*N-1:0]   posx_flat,
   input  logic [9*N-1:0]    posy_flat,
   input  logic [3*N-1:0]    color_flat,
   input  logic [2*N-1:0]    power_flat,
   output logic [5:0]        rgb,
   output logic              hit_any,
   output logic [2:0]        hit_id
);

   localparam int KW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t          state_q;
   logic [9:0]      snap_x_q [N];
   logic [8:0]      snap_y_q [N];
   logic [2:0]      snap_c_q [N];
   logic [1:0]      snap_p_q [N];
   logic [3:0]      frame_cnt_q;
   logic            snap_pending_q;
   logic [9:0]      vnext_q;
   logic [KW-1:0]   k_q;
   logic [N-1:0]    pend_mask_q;
   logic [N-1:0]    line_mask_q;
   logic            s1_any_q;
   logic [2:0]      s1_id_q;
   logic            s1_va_q;
   logic [5:0]      rgb_q;
   logic            hit_any_q;
   logic [2:0]      hit_id_q;

   logic            scan_hit_d;
   logic            any_d;
   logic [2:0]      id_d;
   logic [5:0]      colour_d;

   function automatic logic [5:0] palette(input logic [2:0] idx);
      case (idx)
         3'd0:    palette = 6'b110000;
         3'd1:    palette = 6'b001100;
         3'd2:    palette = 6'b000011;
         3'd3:    palette = 6'b111100;
         3'd4:    palette = 6'b110011;
         3'd5:    palette = 6'b001111;
         3'd6:    palette = 6'b111111;
         default: palette = 6'b100100;
      endcase
   endfunction

   // Shadow copy of the game state; a tick seen mid-scan is deferred to the next IDLE cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            snap_x_q[i] <= 10'd0;
            snap_y_q[i] <= 9'd0;
            snap_c_q[i] <= 3'd0;
            snap_p_q[i] <= 2'd0;
         end
         frame_cnt_q    <= 4'd0;
         snap_pending_q <= 1'b0;
      end else if (state_q == IDLE && (frame_tick || snap_pending_q)) begin
         for (int i = 0; i < N; i++) begin
            snap_x_q[i] <= posx_flat[10*i +: 10];
            snap_y_q[i] <= posy_flat[9*i +: 9];
            snap_c_q[i] <= color_flat[3*i +: 3];
            snap_p_q[i] <= power_flat[2*i +: 2];
         end
         frame_cnt_q    <= frame_cnt_q + 4'd1;
         snap_pending_q <= 1'b0;
      end else if (frame_tick) begin
         snap_pending_q <= 1'b1;
      end
   end

   // Vertical coverage test for box k against the upcoming line.
   always_comb begin
      scan_hit_d = 1'b0;
      if (vnext_q < 10'(SCREEN_H)) begin
         scan_hit_d = ({1'b0, snap_y_q[k_q]} <= vnext_q) &&
                      (vnext_q < {1'b0, snap_y_q[k_q]} + 10'(BOX_H));
      end else begin
         scan_hit_d = 1'b0;
      end
   end

   // Line FSM: one box per clock during blank, mask handed over at the last pixel of the line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         vnext_q     <= 10'd0;
         k_q         <= '0;
         pend_mask_q <= '0;
         line_mask_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (hpos == 10'(SCREEN_W)) begin
                  vnext_q <= (vpos == 10'(V_TOTAL - 1)) ? 10'd0 : vpos + 10'd1;
                  k_q     <= '0;
                  state_q <= SCAN;
               end
            end
            SCAN: begin
               pend_mask_q[k_q] <= scan_hit_d;
               k_q              <= k_q + KW'(1);
               if (k_q == KW'(N - 1)) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (hpos == 10'(H_TOTAL - 1)) begin
                  line_mask_q <= pend_mask_q;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Horizontal coverage with lowest-index priority; 11-bit compare so x+BOX_W never wraps.
   always_comb begin
      any_d = 1'b0;
      id_d  = 3'd0;
      for (int i = N - 1; i >= 0; i--) begin
         if (line_mask_q[i] &&
             ({1'b0, snap_x_q[i]} <= {1'b0, hpos}) &&
             ({1'b0, hpos} < {1'b0, snap_x_q[i]} + 11'(BOX_W))) begin
            any_d = 1'b1;
            id_d  = 3'(i);
         end else begin
            any_d = any_d;
            id_d  = id_d;
         end
      end
   end

   // Colour lookup with power-state blink during the upper half of the 16-frame cycle.
   always_comb begin
      colour_d = BG_RGB;
      if (s1_any_q) begin
         colour_d = palette(snap_c_q[s1_id_q]);
         if (snap_p_q[s1_id_q] == 2'd1 && frame_cnt_q[3]) begin
            colour_d = ~palette(snap_c_q[s1_id_q]);
         end else begin
            colour_d = palette(snap_c_q[s1_id_q]);
         end
      end else begin
         colour_d = BG_RGB;
      end
   end

   // Two-stage pixel pipeline.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_any_q  <= 1'b0;
         s1_id_q   <= 3'd0;
         s1_va_q   <= 1'b0;
         rgb_q     <= 6'd0;
         hit_any_q <= 1'b0;
         hit_id_q  <= 3'd0;
      end else begin
         s1_any_q <= any_d;
         s1_id_q  <= id_d;
         s1_va_q  <= video_active;
         if (s1_va_q) begin
            rgb_q     <= colour_d;
            hit_any_q <= s1_any_q;
            hit_id_q  <= s1_any_q ? s1_id_q : 3'd0;
         end else begin
            rgb_q     <= 6'd0;
            hit_any_q <= 1'b0;
            hit_id_q  <= 3'd0;
         end
      end
   end

   assign rgb     = rgb_q;
   assign hit_any = hit_any_q;
   assign hit_id  = hit_id_q;

endmodule

// File: doc/box_sprite_renderer.md
Name: box_sprite_renderer

Overview:
Display-side consumer of the game core's per-dog state (posx, posy, color_idx, power_state). It snapshots that state once per frame, builds a per-scanline active-box mask during horizontal blank, and resolves each pixel to a 6-bit RGB value through a 2-stage pipeline. It sits between the game core and the VGA output, driven by vga_timing's hpos/vpos/video_active/frame_tick.

Parameters:
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in lines
H_TOTAL, 800, total pixels per line including blank
V_TOTAL, 525, total lines per frame including blank
BOX_W, 48, box width in pixels
BOX_H, 32, box height in lines
N, 8, number of boxes
BG_RGB, 6'b000001, background colour as {R[1:0],G[1:0],B[1:0]}

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse per frame from vga_timing
hpos  in  10  current pixel column, 0..H_TOTAL-1
vpos  in  10  current line, 0..V_TOTAL-1
video_active  in  1  high inside the visible area
posx_flat  in  10*N  box i x at [10i+9:10i]
posy_flat  in  9*N  box i y at [9i+8:9i]
color_flat  in  3*N  box i colour index at [3i+2:3i]
power_flat  in  2*N  box i power_state at [2i+1:2i]
rgb  out  6  pixel colour {R,G,B}, 2 bits each
hit_any  out  1  a box covers the pixel currently on rgb
hit_id  out  3  lowest covering box index, valid when hit_any

Behaviour:
- Reset: rgb=0, hit_any=0, hit_id=0. All snapshot regs, line_mask, pend_mask and frame_cnt (4 bits) are 0. FSM goes to IDLE and snap_pending is 0.
- Snapshot: on frame_tick with FSM in IDLE, all four input buses are copied to shadow registers, and frame_cnt increments (wraps at 16). If FSM is not IDLE, snap_pending is set instead. The copy and increment happen on the first cycle back in IDLE, and snap_pending is then cleared. Shadow values are used from the cycle after capture.
- Line FSM states:
  - IDLE -> SCAN when hpos==SCREEN_W. At entry, latch vnext = (vpos==V_TOTAL-1) ? 0 : vpos+1 and clear k.
  - SCAN tests one box per clock. pend_mask[k] = (snap_y[k] <= vnext) && (vnext < snap_y[k]+BOX_H), compared at 10-bit width with no wrap.
  - After box N-1, SCAN -> DONE (N cycles in SCAN).
  - DONE waits for hpos==H_TOTAL-1, copies pend_mask to line_mask, then goes to IDLE. line_mask is therefore valid from hpos==0 of line vnext.
  - If vnext >= SCREEN_H, pend_mask is forced to 0 and SCAN still runs N cycles.
- Pixel pipeline, 2-cycle latency. rgb/hit_* at cycle t+2 reflect hpos/vpos/video_active at cycle t.
  - Stage 1: cover[i] = line_mask[i] && snap_x[i] <= hpos < snap_x[i]+BOX_W, compared at 11 bits. A lowest-index priority encoder gives id/any. video_active is registered alongside.
  - Stage 2: colour = PALETTE[snap_color[id]] if any, else BG_RGB. If any && snap_power[id]==1 && frame_cnt[3]==1, colour is bitwise inverted. If the registered video_active is 0, rgb=0 and hit_any=0.
  - PALETTE, fixed: 0:110000, 1:001100, 2:000011, 3:111100, 4:110011, 5:001111, 6:111111, 7:100100.
- Boxes at snap_x+BOX_W > SCREEN_W are clipped naturally by video_active. Snapshot changes mid-frame are impossible by construction.
- Reset asserted mid-line returns the block to reset values immediately. The first line after reset shows background until a full SCAN/DONE cycle completes.

Test Plan:
- Box 0 snapshot at (100,50), colour 2; frame_tick; then line 50, hpos 100..147 -> rgb=000011 and hit_id=0 exactly 2 cycles after each hpos. hpos 99 and 148 -> BG_RGB.
- Boxes 1 and 3 overlap at (200,200) -> hit_id=1 on overlap pixels. Box 3 shows only where box 1 is absent.
- Box at y=479 -> only line 479 is covered. Box at y=10: line 9 shows background, lines 10..41 are covered, line 42 shows background. Check vpos wrap 524->0: line 0 uses the mask scanned with vnext=0.
- frame_tick pulsed while FSM is in SCAN -> snapshot is not taken until IDLE. The next frame shows the new positions and no line mixes old and new values.
- Box power_state=1 -> inverted colour for frames where frame_cnt[3]=1 (frames 8..15), normal colour for frames 0..7.
- rst_n pulsed low mid-line -> rgb=0 asynchronously. Background is shown (video_active high) until the next completed scan.
